// File: rtl/aim65_vterm_pkg.sv
// Shared constants, state encoding and address wrap helper for the AIM65 40x25 terminal writer.
package aim65_vterm_pkg;

  localparam int COLS        = 40;
  localparam int ROWS        = 25;
  localparam int SCREEN_SIZE = COLS * ROWS;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL,
    ST_LINE_CLR,
    ST_CLR_WAIT
  } vterm_state_t;

  // Sums never reach 2*SCREEN_SIZE, so a single conditional subtract suffices.
  function automatic logic [9:0] wrap_addr(input logic [10:0] sum);
    if (sum >= 11'(SCREEN_SIZE)) return 10'(sum - 11'(SCREEN_SIZE));
    return sum[9:0];
  endfunction

endpackage

// File: rtl/aim65_vterm_addr_gen.sv
// Combinational logical-to-physical address map: base + row*COLS + col, wrapped into 0..999.
module aim65_vterm_addr_gen
  import aim65_vterm_pkg::*;
(
  input  logic [9:0] i_base,
  input  logic [4:0] i_row,
  input  logic [5:0] i_col,
  output logic [9:0] o_addr
);

  logic [10:0] w_sum;

  assign w_sum  = 11'(i_base) + (11'(i_row) * 11'(COLS)) + 11'(i_col);
  assign o_addr = wrap_addr(w_sum);

endmodule

// File: rtl/aim65_vterm_writer.sv
// AIM65 terminal writer: turns an ASCII byte stream into display RAM writes, clears and scrolls.
// Optional build macro AIM65_VTERM_AUTOWRAP_EN: writing column 39 wraps to the next line.
module aim65_vterm_writer
  import aim65_vterm_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR  = 8'h00,
  parameter int         VSCROLL_LEN = 4,
  parameter int         CLEAR_WAIT  = 1001
) (
  input  logic       cpu_clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       video_ce,
  output logic       video_we,
  output logic [9:0] video_addr,
  output logic [7:0] video_data,
  output logic       video_clear,
  output logic       video_vscroll,
  output logic [5:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam logic [5:0]  L_COL_LAST  = 6'(COLS - 1);
  localparam logic [4:0]  L_ROW_LAST  = 5'(ROWS - 1);
  localparam logic [9:0]  L_BASE_LAST = 10'(SCREEN_SIZE - COLS);
  localparam logic [9:0]  L_ROW_STEP  = 10'(COLS);
  localparam logic [10:0] L_VS_LAST   = 11'(VSCROLL_LEN - 1);
  localparam logic [10:0] L_CW_LAST   = 11'(CLEAR_WAIT - 1);
  localparam logic [10:0] L_CLR_DONE  = 11'(COLS);

  vterm_state_t r_state, w_state_nxt;
  logic [10:0]  r_cnt, w_cnt_nxt;
  logic [9:0]   r_base, w_base_nxt;
  logic [4:0]   r_row, w_row_nxt;
  logic [5:0]   r_col, w_col_nxt;
  logic         r_ce, w_ce_nxt;
  logic [9:0]   r_addr, w_addr_nxt;
  logic [7:0]   r_data, w_data_nxt;
  logic         r_clear, w_clear_nxt;
  logic         r_vscroll, w_vscroll_nxt;
`ifdef AIM65_VTERM_AUTOWRAP_EN
  logic         r_wrap, w_wrap_nxt;
`endif

  logic         w_accept;
  logic [9:0]   w_base_adv;
  logic [4:0]   w_gen_row;
  logic [5:0]   w_gen_col;
  logic [9:0]   w_addr;

  assign char_ready    = (r_state == ST_IDLE) & ~reset;
  assign w_accept      = char_valid & char_ready;
  assign busy          = (r_state != ST_IDLE);
  assign video_ce      = r_ce;
  assign video_we      = r_ce;
  assign video_addr    = r_addr;
  assign video_data    = r_data;
  assign video_clear   = r_clear;
  assign video_vscroll = r_vscroll;
  assign cursor_col    = r_col;
  assign cursor_row    = r_row;

  // base is always a multiple of COLS, so the wrap point is exactly the last row start.
  assign w_base_adv = (r_base == L_BASE_LAST) ? 10'd0 : (r_base + L_ROW_STEP);

  // One address generator serves both cursor writes (IDLE) and bottom-line clears.
  always_comb begin
    w_gen_row = L_ROW_LAST;
    w_gen_col = '0;
    if (r_state == ST_IDLE) begin
      w_gen_row = r_row;
      w_gen_col = r_col;
    end else if (r_state == ST_LINE_CLR) begin
      w_gen_col = r_cnt[5:0];
    end
  end

  aim65_vterm_addr_gen u_addr_gen (
    .i_base (r_base),
    .i_row  (w_gen_row),
    .i_col  (w_gen_col),
    .o_addr (w_addr)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_base_nxt    = r_base;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_ce_nxt      = 1'b0;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_clear_nxt   = 1'b0;
    w_vscroll_nxt = 1'b0;
`ifdef AIM65_VTERM_AUTOWRAP_EN
    w_wrap_nxt    = r_wrap;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (char_data >= ASCII_SPACE) begin
            w_state_nxt = ST_WRITE;
            w_ce_nxt    = 1'b1;
            w_addr_nxt  = w_addr;
            w_data_nxt  = char_data;
`ifdef AIM65_VTERM_AUTOWRAP_EN
            if (r_col == L_COL_LAST) w_wrap_nxt = 1'b1;
            else                     w_col_nxt  = r_col + 6'd1;
`else
            if (r_col != L_COL_LAST) w_col_nxt = r_col + 6'd1;
`endif
          end else begin
            case (char_data)
              ASCII_CR: w_col_nxt = '0;
              ASCII_LF: begin
                if (r_row != L_ROW_LAST) begin
                  w_row_nxt = r_row + 5'd1;
                end else begin
                  w_state_nxt   = ST_SCROLL;
                  w_base_nxt    = w_base_adv;
                  w_col_nxt     = '0;
                  w_cnt_nxt     = '0;
                  w_vscroll_nxt = 1'b1;
                end
              end
              ASCII_BS: if (r_col != '0) w_col_nxt = r_col - 6'd1;
              ASCII_FF: begin
                w_state_nxt = ST_CLR_WAIT;
                w_clear_nxt = 1'b1;
                w_base_nxt  = '0;
                w_row_nxt   = '0;
                w_col_nxt   = '0;
                w_cnt_nxt   = '0;
              end
              default: ;
            endcase
          end
        end
      end

      ST_WRITE: begin
        w_state_nxt = ST_IDLE;
`ifdef AIM65_VTERM_AUTOWRAP_EN
        if (r_wrap) begin
          w_wrap_nxt = 1'b0;
          w_col_nxt  = '0;
          if (r_row != L_ROW_LAST) begin
            w_row_nxt = r_row + 5'd1;
          end else begin
            w_state_nxt   = ST_SCROLL;
            w_base_nxt    = w_base_adv;
            w_cnt_nxt     = '0;
            w_vscroll_nxt = 1'b1;
          end
        end
`endif
      end

      // The first clear write is issued as vscroll drops, so strobes never overlap it.
      ST_SCROLL: begin
        if (r_cnt == L_VS_LAST) begin
          w_state_nxt = ST_LINE_CLR;
          w_ce_nxt    = 1'b1;
          w_addr_nxt  = w_addr;
          w_data_nxt  = CLEAR_CHAR;
          w_cnt_nxt   = 11'd1;
        end else begin
          w_vscroll_nxt = 1'b1;
          w_cnt_nxt     = r_cnt + 11'd1;
        end
      end

      ST_LINE_CLR: begin
        if (r_cnt == L_CLR_DONE) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_ce_nxt   = 1'b1;
          w_addr_nxt = w_addr;
          w_data_nxt = CLEAR_CHAR;
          w_cnt_nxt  = r_cnt + 11'd1;
        end
      end

      ST_CLR_WAIT: begin
        if (r_cnt == L_CW_LAST) w_state_nxt = ST_IDLE;
        else                    w_cnt_nxt   = r_cnt + 11'd1;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_base    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_ce      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_clear   <= 1'b0;
      r_vscroll <= 1'b0;
`ifdef AIM65_VTERM_AUTOWRAP_EN
      r_wrap    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_base    <= w_base_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_ce      <= w_ce_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_clear   <= w_clear_nxt;
      r_vscroll <= w_vscroll_nxt;
`ifdef AIM65_VTERM_AUTOWRAP_EN
      r_wrap    <= w_wrap_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_aim65_vterm_writer.sv
// Scoreboard bench for aim65_vterm_writer: a cursor/base screen model predicts RAM writes and pulses.
module tb_aim65_vterm_writer;

  localparam int VSCROLL_LEN = 4;
  localparam int CLEAR_WAIT  = 1001;

  logic       cpu_clk;
  logic       reset;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       video_ce, video_we;
  logic [9:0] video_addr;
  logic [7:0] video_data;
  logic       video_clear, video_vscroll;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  aim65_vterm_writer dut (
    .cpu_clk       (cpu_clk),
    .reset         (reset),
    .char_valid    (char_valid),
    .char_data     (char_data),
    .char_ready    (char_ready),
    .video_ce      (video_ce),
    .video_we      (video_we),
    .video_addr    (video_addr),
    .video_data    (video_data),
    .video_clear   (video_clear),
    .video_vscroll (video_vscroll),
    .cursor_col    (cursor_col),
    .cursor_row    (cursor_row),
    .busy          (busy)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {int addr; int data;} wr_t;
  wr_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int m_row = 0, m_col = 0, m_base = 0;
  int exp_scrolls = 0, exp_clears = 0;
  int obs_scrolls = 0, obs_clears = 0;
  int vs_len = 0, clr_len = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a screen is a ring of 1000 cells whose top row starts at base.
  function automatic void model_lf();
    if (m_row < 24) begin
      m_row++;
    end else begin
      m_base = (m_base + 40) % 1000;
      exp_scrolls++;
      for (int c = 0; c < 40; c++) exp_q.push_back('{(m_base + 24 * 40 + c) % 1000, 0});
      m_col = 0;
    end
  endfunction

  function automatic void model_step(input logic [7:0] b);
    if (b >= 8'h20) begin
      exp_q.push_back('{(m_base + m_row * 40 + m_col) % 1000, int'(b)});
`ifdef AIM65_VTERM_AUTOWRAP_EN
      if (m_col == 39) begin m_col = 0; model_lf(); end
      else m_col++;
`else
      if (m_col < 39) m_col++;
`endif
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      model_lf();
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) begin
      m_base = 0; m_row = 0; m_col = 0;
      exp_clears++;
    end
  endfunction

  // Monitor: pops one expected write per strobe and measures pulse widths.
  always @(negedge cpu_clk) begin
    if (video_ce) begin
      chk("we_with_ce", int'(video_we), 1);
      chk("strobe_overlap", int'(video_vscroll | video_clear), 0);
      chk("write_was_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", int'(video_addr), e.addr);
        chk("write_data", int'(video_data), e.data);
      end
    end
    if (video_vscroll) vs_len++;
    else if (vs_len != 0) begin
      chk("vscroll_len", vs_len, VSCROLL_LEN);
      obs_scrolls++;
      vs_len = 0;
    end
    if (video_clear) clr_len++;
    else if (clr_len != 0) begin
      chk("clear_len", clr_len, 1);
      obs_clears++;
      clr_len = 0;
    end
  end

  task automatic accept_byte(input logic [7:0] b);
    int g;
    g = 0;
    @(negedge cpu_clk);
    while (!char_ready && g < 5000) begin @(negedge cpu_clk); g++; end
    chk("ready_before_send", int'(char_ready), 1);
    char_valid = 1'b1;
    char_data  = b;
    @(posedge cpu_clk); #1;
    char_valid = 1'b0;
    char_data  = 8'($urandom);
    model_step(b);
  endtask

  task automatic wait_idle(output int low);
    low = 0;
    @(negedge cpu_clk);
    while (!char_ready && low < 5000) begin low++; @(negedge cpu_clk); end
    chk("ready_returns", int'(char_ready), 1);
    chk("cursor_col", int'(cursor_col), m_col);
    chk("cursor_row", int'(cursor_row), m_row);
  endtask

  // exp_low < 0 means the busy time is not checked for this byte.
  task automatic send(input logic [7:0] b, input int exp_low);
    int low;
    accept_byte(b);
    wait_idle(low);
    if (exp_low >= 0) chk("ready_low_cycles", low, exp_low);
  endtask

  function automatic int expected_low(input logic [7:0] b);
    if (b >= 8'h20) begin
`ifdef AIM65_VTERM_AUTOWRAP_EN
      if (m_col == 39) return -1;
`endif
      return 1;
    end
    if (b == 8'h0A) return (m_row < 24) ? 0 : -1;
    if (b == 8'h0C) return CLEAR_WAIT;
    return 0;
  endfunction

  task automatic check_reset_outputs(input int ready_exp);
    chk("rst_ce", int'(video_ce), 0);
    chk("rst_we", int'(video_we), 0);
    chk("rst_addr", int'(video_addr), 0);
    chk("rst_data", int'(video_data), 0);
    chk("rst_clear", int'(video_clear), 0);
    chk("rst_vscroll", int'(video_vscroll), 0);
    chk("rst_col", int'(cursor_col), 0);
    chk("rst_row", int'(cursor_row), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(char_ready), ready_exp);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r;
    reset      = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    repeat (3) @(posedge cpu_clk);
    #1;
    check_reset_outputs(0);
    reset = 1'b0;
    @(negedge cpu_clk);
    chk("ready_after_reset", int'(char_ready), 1);

    // First printable lands at address 0 and blocks for one cycle.
    send(8'h41, 1);

    // Cursor-only controls.
    send(8'h0D, 0);
    send(8'h08, 0);
    for (int i = 0; i < 17; i++) send(8'($urandom_range(32, 126)), 1);
    send(8'h0D, 0);
    send(8'h07, 0);

    // A full row of 'B' from column 0.
    for (int i = 0; i < 40; i++) begin
      b = 8'h42;
      send(b, expected_low(b));
    end
    send(8'h0D, 0);

    // Walk to the bottom row, scroll once, then write at the new bottom-left.
    while (m_row < 24) send(8'h0A, 0);
    send(8'h0A, -1);
    send(8'h43, 1);

    // Randomized mixed stream.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 199);
      if (r < 120)      b = 8'($urandom_range(32, 255));
      else if (r < 150) b = 8'h0A;
      else if (r < 165) b = 8'h0D;
      else if (r < 180) b = 8'h08;
      else if (r < 198) begin
        b = 8'($urandom_range(0, 31));
        while (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'($urandom_range(0, 31));
      end else b = 8'h0C;
      send(b, expected_low(b));
    end

    // Form feed from mid-screen, then first character lands at 0.
    send(8'h0A, -1);
    send(8'h51, -1);
    send(8'h0C, CLEAR_WAIT);
    send(8'h44, 1);

    // Reset in the middle of the bottom-line clear.
    while (m_row < 24) send(8'h0A, 0);
    accept_byte(8'h0A);
    repeat (10) @(posedge cpu_clk);
    #1;
    reset = 1'b1;
    @(posedge cpu_clk); #1;
    exp_q.delete();
    m_base = 0; m_row = 0; m_col = 0;
    check_reset_outputs(0);
    repeat (2) @(posedge cpu_clk);
    #1;
    reset = 1'b0;
    @(negedge cpu_clk);
    chk("ready_after_abort", int'(char_ready), 1);
    send(8'h45, 1);

    repeat (5) @(negedge cpu_clk);
    chk("pending_writes_left", exp_q.size(), 0);
    chk("scroll_count", obs_scrolls, exp_scrolls);
    chk("clear_count", obs_clears, exp_clears);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
